swap_ctl_sched: RTL and testbench

//  Clocked scheduler that drives the dual-rail control channel of a swap element.

---
 rtl/swap_ctl_sched.sv | 163 ++++++++++++++++
 tb/tb_swap_ctl_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/swap_ctl_sched.sv
// rtl/swap_ctl_sched.sv - dual-rail control-channel scheduler for a swap element
// Arbitrates the two data-channel requests and runs a 4-phase handshake on ctl_a/ctl_b.
module swap_ctl_sched #(
  parameter int SYNC = 2,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          req0,
  input  logic          req1,
  output logic          ctl_a,
  output logic          ctl_b,
  input  logic          actl_i,
  output logic          busy,
  output logic          last_sel,
  output logic [CW-1:0] tok_cnt,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ASSERT, S_RELEASE} state_t;

  localparam logic [2:0] SETTLE = 3'(SYNC);

  logic [1:0]      rst_sync_q;
  logic            rst_n;
  logic [SYNC-1:0] r0_sync_q, r1_sync_q, a_sync_q;
  logic            r0s, r1s, as;
  logic [2:0]      settle_q, settle_d;
  logic            settled;
  logic            armed_q, armed_d;
  logic            as_prev_q;
  state_t          state_q, state_d;
  logic            ctl_a_q, ctl_a_d, ctl_b_q, ctl_b_d;
  logic            last_sel_q, last_sel_d;
  logic [CW-1:0]   tok_cnt_q, tok_cnt_d;
  logic            err_q, err_d;
  logic            grant, sel;

  // Reset asserts asynchronously and releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_sync_q <= '0;
      r1_sync_q <= '0;
      a_sync_q  <= '0;
    end else begin
      r0_sync_q <= {r0_sync_q[SYNC-2:0], req0};
      r1_sync_q <= {r1_sync_q[SYNC-2:0], req1};
      a_sync_q  <= {a_sync_q[SYNC-2:0], actl_i};
    end
  end
  assign r0s = r0_sync_q[SYNC-1];
  assign r1s = r1_sync_q[SYNC-1];
  assign as  = a_sync_q[SYNC-1];

  // The ack synchroniser only reflects the real pin once it has refilled after
  // reset; until an ack low has been seen past that point, no token and no error.
  assign settled  = (settle_q == SETTLE);
  assign settle_d = settled ? settle_q : settle_q + 3'd1;
  assign armed_d  = armed_q | (settled & ~as);

  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    case (mode)
      2'd0: begin
        if (r0s && r1s) begin grant = 1'b1; sel = ~last_sel_q; end
        else if (r0s)   begin grant = 1'b1; sel = 1'b0; end
        else if (r1s)   begin grant = 1'b1; sel = 1'b1; end
      end
      2'd1: begin
        if (r0s)        begin grant = 1'b1; sel = 1'b0; end
        else if (r1s)   begin grant = 1'b1; sel = 1'b1; end
      end
      2'd2: begin
        if (r1s)        begin grant = 1'b1; sel = 1'b1; end
        else if (r0s)   begin grant = 1'b1; sel = 1'b0; end
      end
      default: begin
        sel   = ~last_sel_q;
        grant = sel ? r1s : r0s;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en && armed_q && !as && (r0s || r1s)) state_d = S_ARB;
      S_ARB:     state_d = grant ? S_ASSERT : S_IDLE;
      S_ASSERT:  if (as)  state_d = S_RELEASE;
      S_RELEASE: if (!as) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_a_d    = ctl_a_q;
    ctl_b_d    = ctl_b_q;
    last_sel_d = last_sel_q;
    tok_cnt_d  = tok_cnt_q;
    err_d      = err_q | ((state_q == S_IDLE) && armed_q && as && !as_prev_q);
    case (state_q)
      S_ARB: begin
        if (grant) begin
          ctl_a_d    = ~sel;
          ctl_b_d    = sel;
          last_sel_d = sel;
        end
      end
      S_ASSERT: begin
        if (as) begin
          ctl_a_d = 1'b0;
          ctl_b_d = 1'b0;
        end
      end
      S_RELEASE: if (!as) tok_cnt_d = tok_cnt_q + CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_a_q    <= 1'b0;
      ctl_b_q    <= 1'b0;
      last_sel_q <= 1'b1;
      tok_cnt_q  <= '0;
      err_q      <= 1'b0;
      settle_q   <= 3'd0;
      armed_q    <= 1'b0;
      as_prev_q  <= 1'b0;
    end else begin
      ctl_a_q    <= ctl_a_d;
      ctl_b_q    <= ctl_b_d;
      last_sel_q <= last_sel_d;
      tok_cnt_q  <= tok_cnt_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      as_prev_q  <= as;
    end
  end

  assign ctl_a    = ctl_a_q;
  assign ctl_b    = ctl_b_q;
  assign last_sel = last_sel_q;
  assign tok_cnt  = tok_cnt_q;
  assign err      = err_q;
  assign busy     = (state_q == S_ASSERT) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_swap_ctl_sched.sv
// tb/tb_swap_ctl_sched.sv - directed scoreboard bench for swap_ctl_sched
module tb_swap_ctl_sched;

  logic       clk = 1'b0;
  logic       rst, en, req0, req1, ack_drv, loop;
  logic [1:0] mode;
  logic       ctl_a, ctl_b, busy, last_sel, err, actl;
  logic [7:0] tok_cnt;

  logic       en2, req2;
  logic       ctl_a2, ctl_b2, busy2, last_sel2, err2, actl2;
  logic [2:0] tok2;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  assign actl  = loop ? (ctl_a | ctl_b) : ack_drv;
  assign actl2 = ctl_a2 | ctl_b2;

  swap_ctl_sched #(.SYNC(2), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .req0(req0), .req1(req1),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .actl_i(actl), .busy(busy),
    .last_sel(last_sel), .tok_cnt(tok_cnt), .err(err)
  );

  swap_ctl_sched #(.SYNC(2), .CW(3)) dut_w (
    .clk(clk), .rst(rst), .en(en2), .mode(2'd0), .req0(req2), .req1(1'b0),
    .ctl_a(ctl_a2), .ctl_b(ctl_b2), .actl_i(actl2), .busy(busy2),
    .last_sel(last_sel2), .tok_cnt(tok2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every rising rail is a token: pop the channel the stimulus predicted.
  logic pa = 1'b0, pb = 1'b0;
  always @(negedge clk) begin
    if ((ctl_a && !pa) || (ctl_b && !pb)) begin
      int sz;
      sz = exp_q.size();
      chk("rails_exclusive", 32'(ctl_a & ctl_b), 32'd0);
      n_assert++;
      assert (sz > 0) else begin
        n_fail++;
        $error("FAIL unexpected_token: observed ch%0d expected none", ctl_b);
      end
      if (sz > 0) chk("token_channel", 32'(ctl_b), 32'(exp_q.pop_front()));
    end
    pa = ctl_a;
    pb = ctl_b;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; en2 = 1'b0;
    cycles(3);
    chk("rst_ctl_a", 32'(ctl_a), 32'd0);
    chk("rst_ctl_b", 32'(ctl_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_sel", 32'(last_sel), 32'd1);
    chk("rst_tok_cnt", 32'(tok_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    cycles(8);
  endtask

  task automatic wait_tok(input logic [7:0] target, input int budget, input string tag);
    for (int i = 0; i < budget && tok_cnt != target; i++) @(negedge clk);
    chk(tag, 32'(tok_cnt), 32'(target));
  endtask

  task automatic wait_rail(input logic level, input int budget, input string tag);
    for (int i = 0; i < budget && ctl_a != level; i++) @(negedge clk);
    chk(tag, 32'(ctl_a), 32'(level));
  endtask

  initial begin
    int seen;
    logic [2:0] prev;
    rst = 1'b0; en = 1'b0; req0 = 1'b0; req1 = 1'b0; ack_drv = 1'b0; loop = 1'b0;
    mode = 2'd0; en2 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    do_reset();

    // Latency of a single ch0 token with a hand-driven ack.
    exp_q.push_back(1'b0);
    req0 = 1'b1; en = 1'b1;
    cycles(3);
    chk("t1_rail_not_yet", 32'(ctl_a), 32'd0);
    cycles(1);
    chk("t1_rail_up", 32'(ctl_a), 32'd1);
    chk("t1_ctl_b", 32'(ctl_b), 32'd0);
    chk("t1_last_sel", 32'(last_sel), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    ack_drv = 1'b1;
    cycles(2);
    chk("t1_rail_held", 32'(ctl_a), 32'd1);
    cycles(1);
    chk("t1_rail_down", 32'(ctl_a), 32'd0);
    chk("t1_busy_release", 32'(busy), 32'd1);
    req0 = 1'b0; ack_drv = 1'b0;
    wait_tok(8'd1, 20, "t1_tok_cnt");
    en = 1'b0;
    cycles(1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Round-robin alternation under loopback.
    do_reset();
    loop = 1'b1; mode = 2'd0;
    for (int i = 0; i < 6; i++) exp_q.push_back(i[0]);
    req0 = 1'b1; req1 = 1'b1; en = 1'b1;
    wait_tok(8'd6, 300, "t2_tok_cnt");
    en = 1'b0;

    // Priority ch0, then ch1 once req0 has gone.
    mode = 2'd1;
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    cycles(4);
    en = 1'b1;
    wait_tok(8'd12, 300, "t3_tok_cnt");
    en = 1'b0;
    req0 = 1'b0;
    exp_q.push_back(1'b1);
    cycles(4);
    en = 1'b1;
    wait_tok(8'd13, 60, "t3_ch1_tok");
    en = 1'b0;

    // Strict alternation starves a non-requesting target.
    req0 = 1'b1; req1 = 1'b0; mode = 2'd0;
    exp_q.push_back(1'b0);
    cycles(4);
    en = 1'b1;
    wait_tok(8'd14, 60, "t4_setup_tok");
    mode = 2'd3;
    cycles(30);
    chk("t4_no_token", 32'(tok_cnt), 32'd14);
    chk("t4_last_sel", 32'(last_sel), 32'd0);
    chk("t4_no_rail", 32'(ctl_a | ctl_b), 32'd0);
    exp_q.push_back(1'b1);
    req1 = 1'b1;
    wait_tok(8'd15, 60, "t4_ch1_tok");
    en = 1'b0;
    chk("t4_last_sel_after", 32'(last_sel), 32'd1);
    req0 = 1'b0; req1 = 1'b0; loop = 1'b0; ack_drv = 1'b0;
    cycles(6);

    // Spurious ack while idle is a sticky error.
    chk("t5_err_before", 32'(err), 32'd0);
    ack_drv = 1'b1;
    cycles(4);
    ack_drv = 1'b0;
    cycles(5);
    chk("t5_err_set", 32'(err), 32'd1);
    cycles(10);
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_tok_kept", 32'(tok_cnt), 32'd15);
    do_reset();

    // Reset during ASSERT with ack high; no token until ack falls.
    mode = 2'd0;
    exp_q.push_back(1'b0);
    req0 = 1'b1; en = 1'b1;
    wait_rail(1'b1, 20, "t6_rail_up");
    ack_drv = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_ctl_a", 32'(ctl_a), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    cycles(2);
    rst = 1'b1;
    cycles(20);
    chk("t6_held_off", 32'(ctl_a), 32'd0);
    chk("t6_no_err", 32'(err), 32'd0);
    exp_q.push_back(1'b0);
    ack_drv = 1'b0;
    wait_rail(1'b1, 20, "t6_token_resumes");
    ack_drv = 1'b1;
    wait_rail(1'b0, 20, "t6_rail_down");
    req0 = 1'b0; ack_drv = 1'b0;
    wait_tok(8'd1, 20, "t6_tok_cnt");
    en = 1'b0;
    chk("t6_err_clear", 32'(err), 32'd0);

    // Narrow counter wraps after 2^3 tokens.
    do_reset();
    req2 = 1'b1; en2 = 1'b1;
    seen = 0;
    prev = tok2;
    for (int i = 0; i < 400 && seen < 9; i++) begin
      @(negedge clk);
      if (tok2 != prev) begin
        seen++;
        prev = tok2;
      end
    end
    en2 = 1'b0; req2 = 1'b0;
    chk("t7_tokens_seen", 32'(seen), 32'd9);
    chk("t7_tok_wrap", 32'(tok2), 32'd1);
    cycles(10);
    chk("t7_idle", 32'(busy2 | ctl_a2 | ctl_b2), 32'd0);
    chk("t7_last_sel", 32'(last_sel2), 32'd0);
    chk("t7_err", 32'(err2), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
